ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Sole owner of the byte-wide RAM/IO bus. Arbitrates between instruction fetch (IF) and the MEM-stage data port.
//  Serialises each 1/2/4-byte access into byte transactions and assembles read data little-endian.
//  Sits between IF/mem and the top-level mem_din/mem_dout/mem_a/mem_wr pins; honours rdy_in and branch flush.
// PARAMETERS
//  ADDR_WIDTH  32  width of all address ports
//  IF_BYTES    4   bytes per instruction fetch (fixed 4 for RV32I)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  rdy_in    in   1   low = pause: no new byte issued
//  flush     in   1   branch taken in EX; aborts an in-flight IF access
//  if_req    in   1   fetch request; held until if_done or flush
//  if_addr   in   32  fetch address
//  if_done   out  1   one-cycle pulse, if_inst valid
//  if_inst   out  32  fetched instruction
//  d_rd_req  in   1   data load request; held until d_done
//  d_wr_req  in   1   data store request; held until d_done
//  d_addr    in   32  data address
//  d_size    in   2   bytes-1: 0=byte, 1=half, 3=word (2 illegal, treated as 3)
//  d_wdata   in   32  store data, byte k = bits[8k+7:8k]
//  d_done    out  1   one-cycle pulse, load/store complete
//  d_rdata   out  32  load data, unused upper bytes zero
//  busy      out  1   high in every state except IDLE
//  mem_din   in   8   RAM/IO read byte (address issued previous cycle)
//  mem_dout  out  8   RAM/IO write byte
//  mem_a     out  32  RAM/IO address
//  mem_wr    out  1   1 = write
// BEHAVIOUR
//  Reset: state=IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, d_done=0, if_inst=0, d_rdata=0, busy=0. Reset mid-access aborts it: no done pulse, mem_wr=0 at the same edge.
//  FSM: IDLE -> READ | WRITE -> DONE -> IDLE. All outputs registered.
//  IDLE arbitration: store/load beats IF (fixed priority); d_wr_req wins over d_rd_req if both asserted (illegal). Address/size latched at grant.
//  READ of N bytes granted at cycle G: mem_a=addr+k in cycle G+1+k (k=0..N-1); mem_din captured into byte k at end of G+2+k; done pulse + data in cycle G+N+2.
//   4-byte fetch: done at G+6. 1-byte load: done at G+3.
//  WRITE of N bytes: mem_a=addr+k, mem_dout=d_wdata byte k, mem_wr=1 in cycle G+1+k; d_done in cycle G+N+1.
//  DONE: exactly one cycle, no arbitration; requester drops req there. Next grant earliest cycle after DONE.
//  Address increment is full 32-bit (wraps 0xFFFFFFFF->0); no alignment check.
//  rdy_in low: no new byte issued, byte counter frozen, mem_wr=0, mem_a held. A byte issued in the previous cycle is still captured. Arbitration suppressed. Resume continues from the next unissued byte, never re-reads one (IO 0x30000 reads are not repeated).
//  flush: in READ for IF -> stop issuing, discard captures, next state IDLE, no if_done. flush in IDLE/DONE or during a data access: ignored for that access. flush in the DONE cycle of an IF read does not retract if_done.
//  Data accesses are never aborted by flush or preempted by IF.
//  IO (mem_a[17:16]==2'b11) is handled identically; no speculative or repeated reads ever issued.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: a last_was_data bit alternates priority. If both requests are pending in IDLE and the previous grant went to data, IF wins; otherwise data wins. Bit is cleared by reset, set by data grants, cleared by IF grants.
//  Undefined: fixed data-over-IF priority as above.
// TESTING
//  IF read 0x0 with RAM[0..3]=13,05,00,00, rdy=1 -> mem_a 0,1,2,3 in G+1..G+4; if_done at G+6 with if_inst=0x00000513.
//  Store word 0xDEADBEEF to 0x100 -> mem_wr=1 G+1..G+4, mem_dout EF,BE,AD,DE at 0x100..0x103; d_done at G+5.
//  if_req and d_rd_req (lb 0x30000) asserted together -> data granted first; one read of 0x30000 only; d_rdata=0x000000xx; IF granted after DONE.
//  IF read in progress, flush at G+3 -> no if_done; mem_a stops advancing; IDLE at G+4; new IF read of target then returns correctly.
//  4-byte load with rdy_in low in G+2..G+4 -> byte0 still captured; no issue while low; each address issued exactly once; d_done at G+9 with correct data.
//  ARB_ROUND_ROBIN_EN defined, both reqs held continuously -> grants alternate data, IF, data; undefined -> data every time while held.

Source files
------------

// File: rtl/ram_arbiter.sv
// Byte-bus owner: arbitrates IF vs data port, serialises 1/2/4-byte accesses, assembles reads little-endian (optional ARB_ROUND_ROBIN_EN).
// Latency: N-byte read done at grant+N+2, N-byte write done at grant+N+1; DONE lasts one cycle.
// Backpressure: rdy_in low freezes byte issue and arbitration; bytes already on the bus are still captured.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int IF_BYTES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  d_rd_req,
    input  logic                  d_wr_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [1:0]            d_size,
    input  logic [31:0]           d_wdata,
    output logic                  d_done,
    output logic [31:0]           d_rdata,
    output logic                  busy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic                  is_if;
    logic [2:0]            nbytes;
    logic [2:0]            issue_cnt;
    logic [2:0]            cap_cnt;
    logic                  issued_q;
    logic                  cap_q;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [31:0]           wdata;
    logic [31:0]           rbuf;

    logic        data_req;
    logic        grant;
    logic        pick_if;
    logic        last_cap;
    logic [2:0]  d_nbytes;
    logic [31:0] cap_merged;

    assign data_req = d_wr_req | d_rd_req;
    assign grant    = (state == S_IDLE) && rdy_in && (data_req || if_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_was_data;
    assign pick_if = if_req && (!data_req || last_was_data);
`else
    assign pick_if = if_req && !data_req;
`endif

    // issued_q: a byte address is on the bus this cycle; cap_q: its data is on mem_din this cycle
    assign last_cap = cap_q && ((cap_cnt + 3'd1) == nbytes);

    always_comb begin
        d_nbytes = 3'd4;
        case (d_size)
            2'd0:    d_nbytes = 3'd1;
            2'd1:    d_nbytes = 3'd2;
            default: d_nbytes = 3'd4;
        endcase
        cap_merged = rbuf;
        cap_merged[{cap_cnt, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            is_if     <= 1'b0;
            nbytes    <= 3'd0;
            issue_cnt <= 3'd0;
            cap_cnt   <= 3'd0;
            issued_q  <= 1'b0;
            cap_q     <= 1'b0;
            next_addr <= '0;
            wdata     <= 32'd0;
            rbuf      <= 32'd0;
            mem_a     <= '0;
            mem_dout  <= 8'd0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_inst   <= 32'd0;
            d_rdata   <= 32'd0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_was_data <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        issue_cnt <= 3'd1;
                        cap_cnt   <= 3'd0;
                        rbuf      <= 32'd0;
                        cap_q     <= 1'b0;
                        busy      <= 1'b1;
                        if (pick_if) begin
                            is_if     <= 1'b1;
                            nbytes    <= 3'(IF_BYTES);
                            mem_a     <= if_addr;
                            next_addr <= if_addr + ADDR_WIDTH'(1);
                            mem_wr    <= 1'b0;
                            issued_q  <= 1'b1;
                            state     <= S_READ;
                        end else begin
                            is_if     <= 1'b0;
                            nbytes    <= d_nbytes;
                            mem_a     <= d_addr;
                            next_addr <= d_addr + ADDR_WIDTH'(1);
                            wdata     <= d_wdata;
                            if (d_wr_req) begin
                                mem_wr   <= 1'b1;
                                mem_dout <= d_wdata[7:0];
                                issued_q <= 1'b0;
                                state    <= S_WRITE;
                            end else begin
                                mem_wr   <= 1'b0;
                                issued_q <= 1'b1;
                                state    <= S_READ;
                            end
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_was_data <= !pick_if;
`endif
                    end
                end
                S_READ: begin
                    if (flush && is_if) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        issued_q <= 1'b0;
                        cap_q    <= 1'b0;
                    end else begin
                        cap_q <= issued_q;
                        if (cap_q) begin
                            rbuf    <= cap_merged;
                            cap_cnt <= cap_cnt + 3'd1;
                        end
                        if (last_cap) begin
                            state    <= S_DONE;
                            issued_q <= 1'b0;
                            if (is_if) begin
                                if_done <= 1'b1;
                                if_inst <= cap_merged;
                            end else begin
                                d_done  <= 1'b1;
                                d_rdata <= cap_merged;
                            end
                        end else if (rdy_in && (issue_cnt != nbytes)) begin
                            mem_a     <= next_addr;
                            next_addr <= next_addr + ADDR_WIDTH'(1);
                            issue_cnt <= issue_cnt + 3'd1;
                            issued_q  <= 1'b1;
                        end else begin
                            issued_q <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (issue_cnt == nbytes) begin
                        mem_wr <= 1'b0;
                        d_done <= 1'b1;
                        state  <= S_DONE;
                    end else if (rdy_in) begin
                        mem_a     <= next_addr;
                        next_addr <= next_addr + ADDR_WIDTH'(1);
                        mem_dout  <= wdata[{issue_cnt, 3'b000} +: 8];
                        mem_wr    <= 1'b1;
                        issue_cnt <= issue_cnt + 3'd1;
                    end else begin
                        mem_wr <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte RAM model (IO byte 0x5A at 0x30000).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy_in, flush, if_req, d_rd_req, d_wr_req;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        if_done, d_done, busy, mem_wr;
    logic [31:0] if_inst, d_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(32), .IF_BYTES(4)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_size(d_size),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    logic [7:0] ram [0:1023];
    bit         wrt [0:1023];

    function automatic logic [7:0] init_byte(input logic [9:0] a);
        case (a)
            10'h000: return 8'h13;
            10'h001: return 8'h05;
            10'h200: return 8'h11;
            10'h201: return 8'h22;
            10'h202: return 8'h33;
            10'h203: return 8'h44;
            10'h3FF: return 8'h77;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (a == 32'h0003_0000) return 8'h5A;
        if (wrt[a[9:0]]) return ram[a[9:0]];
        return init_byte(a[9:0]);
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
            wrt[mem_a[9:0]] <= 1'b1;
        end
        mem_din <= rd(mem_a);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got [0:2];
        int ng;
        int exp_seq [0:2];
        logic [31:0] exp_a [1:7];

        rst = 1'b1; rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0; d_rd_req = 1'b0;
        d_wr_req = 1'b0; if_addr = 32'd0; d_addr = 32'd0; d_size = 2'd0; d_wdata = 32'd0;
        repeat (3) next();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dones", {30'd0, if_done, d_done}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        next();

        // store word 0xDEADBEEF to 0x100
        d_addr = 32'h100; d_size = 2'd3; d_wdata = 32'hDEADBEEF; d_wr_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next();
            if (k <= 4) begin
                check("st_mem_wr", {31'd0, mem_wr}, 32'd1);
                check("st_mem_a", mem_a, 32'h100 + 32'(k - 1));
                check("st_mem_dout", {24'd0, mem_dout}, (32'hDEADBEEF >> (8 * (k - 1))) & 32'hFF);
                check("st_d_done_low", {31'd0, d_done}, 32'd0);
            end else begin
                check("st_d_done", {31'd0, d_done}, 32'd1);
                check("st_mem_wr_off", {31'd0, mem_wr}, 32'd0);
                d_wr_req = 1'b0;
            end
        end
        next();
        check("st_idle", {31'd0, busy}, 32'd0);
        check("st_ram", {rd(32'h103), rd(32'h102), rd(32'h101), rd(32'h100)}, 32'hDEADBEEF);

        // instruction fetch at 0x0
        if_addr = 32'h0; if_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next();
            if (k <= 4) check("if_mem_a", mem_a, 32'(k - 1));
            if (k < 6) check("if_done_low", {31'd0, if_done}, 32'd0);
            else begin
                check("if_done", {31'd0, if_done}, 32'd1);
                check("if_inst", if_inst, 32'h0000_0513);
                if_req = 1'b0;
            end
        end
        next();
        check("if_idle", {31'd0, busy}, 32'd0);

        // IF and IO byte load together: data first, single IO read, then IF
        if_addr = 32'h200; if_req = 1'b1;
        d_addr = 32'h0003_0000; d_size = 2'd0; d_rd_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            next();
            if (k <= 4) check("io_mem_a", mem_a, 32'h0003_0000);
            if (k == 1) check("io_mem_wr", {31'd0, mem_wr}, 32'd0);
            if (k == 3) begin
                check("io_d_done", {31'd0, d_done}, 32'd1);
                check("io_d_rdata", d_rdata, 32'h0000_005A);
                d_rd_req = 1'b0;
            end else check("io_d_done_low", {31'd0, d_done}, 32'd0);
            if (k == 4) check("io_idle_gap", {31'd0, busy}, 32'd0);
            if (k == 5) check("io_if_mem_a", mem_a, 32'h200);
            if (k < 10) check("io_if_done_low", {31'd0, if_done}, 32'd0);
            else begin
                check("io_if_done", {31'd0, if_done}, 32'd1);
                check("io_if_inst", if_inst, 32'h4433_2211);
                if_req = 1'b0;
            end
        end

        // both requests held: grant order
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{1, 2, 1};
`else
        exp_seq = '{1, 1, 1};
`endif
        got = '{0, 0, 0};
        ng = 0;
        if_addr = 32'h0; if_req = 1'b1;
        d_addr = 32'h200; d_size = 2'd0; d_rd_req = 1'b1;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            next();
            if (d_done) begin got[ng] = 1; ng++; end
            else if (if_done) begin got[ng] = 2; ng++; end
            if (ng == 3) begin if_req = 1'b0; d_rd_req = 1'b0; end
        end
        if_req = 1'b0; d_rd_req = 1'b0;
        check("arb_count", 32'(ng), 32'd3);
        for (int i = 0; i < 3; i++) check("arb_order", 32'(got[i]), 32'(exp_seq[i]));
        next();
        check("arb_idle", {31'd0, busy}, 32'd0);

        // flush an in-flight fetch, then fetch the branch target
        if_addr = 32'h0; if_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            next();
            if (k <= 3) check("fl_mem_a", mem_a, 32'(k - 1));
            if (k == 3) begin flush = 1'b1; if_req = 1'b0; end
            if (k == 4) begin
                check("fl_idle", {31'd0, busy}, 32'd0);
                check("fl_mem_a_held", mem_a, 32'h2);
                flush = 1'b0; if_addr = 32'h200; if_req = 1'b1;
            end
            if (k >= 5 && k <= 8) check("fl_tgt_mem_a", mem_a, 32'h200 + 32'(k - 5));
            if (k < 10) check("fl_if_done_low", {31'd0, if_done}, 32'd0);
            else begin
                check("fl_if_done", {31'd0, if_done}, 32'd1);
                check("fl_if_inst", if_inst, 32'h4433_2211);
                if_req = 1'b0;
            end
        end
        next();

        // word load with rdy_in low during G+2..G+4
        exp_a = '{32'h200, 32'h201, 32'h201, 32'h201, 32'h201, 32'h202, 32'h203};
        d_addr = 32'h200; d_size = 2'd3; d_rd_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            next();
            if (k <= 7) check("stall_mem_a", mem_a, exp_a[k]);
            check("stall_mem_wr", {31'd0, mem_wr}, 32'd0);
            if (k == 2) rdy_in = 1'b0;
            if (k == 5) rdy_in = 1'b1;
            if (k < 9) check("stall_done_low", {31'd0, d_done}, 32'd0);
            else begin
                check("stall_d_done", {31'd0, d_done}, 32'd1);
                check("stall_d_rdata", d_rdata, 32'h4433_2211);
                d_rd_req = 1'b0;
            end
        end
        next();

        // halfword load across the address wrap
        d_addr = 32'hFFFF_FFFF; d_size = 2'd1; d_rd_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            next();
            if (k == 1) check("wrap_mem_a0", mem_a, 32'hFFFF_FFFF);
            if (k == 2) check("wrap_mem_a1", mem_a, 32'h0);
            if (k < 4) check("wrap_done_low", {31'd0, d_done}, 32'd0);
            else begin
                check("wrap_d_done", {31'd0, d_done}, 32'd1);
                check("wrap_d_rdata", d_rdata, 32'h0000_1377);
                d_rd_req = 1'b0;
            end
        end
        next();
        check("wrap_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a store
        d_addr = 32'h300; d_size = 2'd3; d_wdata = 32'h0102_0304; d_wr_req = 1'b1;
        next();
        check("mr_mem_wr_on", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        next();
        check("mr_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_mem_a", mem_a, 32'd0);
        check("mr_d_done", {31'd0, d_done}, 32'd0);
        rst = 1'b0; d_wr_req = 1'b0;
        next();
        check("mr_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
